// File: rtl/disp_scan.sv
// disp_scan: multiplexed 6-digit 7-segment display driver.
// Snapshots the six BCD time digits once per frame and scans them one at a
// time. Each scan slot lasts SCAN_DIV cycles. The first BLANK_CYC cycles of a
// slot keep every anode off to suppress ghosting.
// Optional build macro: DISP_ZERO_BLANK_EN. When it is defined, the hours-tens
// digit is blanked whenever its snapshot value is 0.
module disp_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       disp_clock,
    input  logic       reset,
    input  logic [3:0] seg_lsd,
    input  logic [2:0] seg_msd,
    input  logic [3:0] min_lsd,
    input  logic [2:0] min_msd,
    input  logic [3:0] hora_lsd,
    input  logic [2:0] hora_msd,
    output logic [6:0] disp_seg,
    output logic [5:0] disp_an,
    output logic       disp_frame
);

    localparam int            PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
    localparam logic [6:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [5:0]    AN_OFF    = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    // Active-high segment pattern. Any value above max_val shows a dash.
    function automatic logic [6:0] decode_digit(input logic [3:0] val, input logic [3:0] max_val);
        logic [6:0] pat;
        if (val > max_val) begin
            pat = 7'h40;
        end else begin
            case (val)
                4'd0:    pat = 7'h3F;
                4'd1:    pat = 7'h06;
                4'd2:    pat = 7'h5B;
                4'd3:    pat = 7'h4F;
                4'd4:    pat = 7'h66;
                4'd5:    pat = 7'h6D;
                4'd6:    pat = 7'h7D;
                4'd7:    pat = 7'h07;
                4'd8:    pat = 7'h7F;
                4'd9:    pat = 7'h6F;
                default: pat = 7'h40;
            endcase
        end
        return pat;
    endfunction

    logic [PW-1:0] ps_q, ps_d;
    logic [2:0]    idx_q, idx_d;
    logic          run_q, run_d;
    logic          frame_q, frame_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    an_q, an_d;
    logic [3:0]    sh_seg_lsd_q, sh_seg_lsd_d;
    logic [2:0]    sh_seg_msd_q, sh_seg_msd_d;
    logic [3:0]    sh_min_lsd_q, sh_min_lsd_d;
    logic [2:0]    sh_min_msd_q, sh_min_msd_d;
    logic [3:0]    sh_hora_lsd_q, sh_hora_lsd_d;
    logic [2:0]    sh_hora_msd_q, sh_hora_msd_d;
    logic          tick_s, snap_s;
    logic [3:0]    dig_s, max_s;
    logic [6:0]    act_s, pat_s;
    logic [5:0]    hot_s;

    // Prescaler, digit index and snapshot control (entering index 0 latches inputs).
    always_comb begin
        tick_s = (ps_q == PS_LAST);
        snap_s = tick_s && (idx_q >= 3'd5);
        run_d  = run_q | tick_s;
        if (tick_s) begin
            ps_d  = {PW{1'b0}};
            idx_d = (idx_q >= 3'd5) ? 3'd0 : (idx_q + 3'd1);
        end else begin
            ps_d  = ps_q + PW'(1);
            idx_d = idx_q;
        end
        if (snap_s) begin
            sh_seg_lsd_d  = seg_lsd;
            sh_seg_msd_d  = seg_msd;
            sh_min_lsd_d  = min_lsd;
            sh_min_msd_d  = min_msd;
            sh_hora_lsd_d = hora_lsd;
            sh_hora_msd_d = hora_msd;
        end else begin
            sh_seg_lsd_d  = sh_seg_lsd_q;
            sh_seg_msd_d  = sh_seg_msd_q;
            sh_min_lsd_d  = sh_min_lsd_q;
            sh_min_msd_d  = sh_min_msd_q;
            sh_hora_lsd_d = sh_hora_lsd_q;
            sh_hora_msd_d = sh_hora_msd_q;
        end
        frame_d = snap_s;
    end

    // Select and decode the digit for the slot being entered. The shadow
    // next-state is used, so a frame-start slot shows the value sampled on that edge.
    always_comb begin
        case (idx_d)
            3'd0:    begin dig_s = sh_seg_lsd_d;          max_s = 4'd9; end
            3'd1:    begin dig_s = {1'b0, sh_seg_msd_d};  max_s = 4'd5; end
            3'd2:    begin dig_s = sh_min_lsd_d;          max_s = 4'd9; end
            3'd3:    begin dig_s = {1'b0, sh_min_msd_d};  max_s = 4'd5; end
            3'd4:    begin dig_s = sh_hora_lsd_d;         max_s = 4'd9; end
            3'd5:    begin dig_s = {1'b0, sh_hora_msd_d}; max_s = 4'd5; end
            default: begin dig_s = 4'd15;                 max_s = 4'd9; end
        endcase
        act_s = decode_digit(dig_s, max_s);
        pat_s = (SEG_ACTIVE_LOW != 0) ? ~act_s : act_s;
`ifdef DISP_ZERO_BLANK_EN
        if ((idx_d == 3'd5) && (sh_hora_msd_d == 3'd0)) begin
            pat_s = SEG_OFF;
        end else begin
            pat_s = pat_s;
        end
`endif
    end

    // Next output pins: the pattern is loaded at slot start, and the anode waits out the blanking window.
    always_comb begin
        hot_s = 6'd1 << idx_d;
        if (tick_s) begin
            seg_d = pat_s;
        end else begin
            seg_d = seg_q;
        end
        if (!run_d || (ps_d < BLANK_LIM)) begin
            an_d = AN_OFF;
        end else begin
            an_d = (AN_ACTIVE_LOW != 0) ? ~hot_s : hot_s;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge disp_clock or negedge reset) begin
        if (!reset) begin
            ps_q          <= {PW{1'b0}};
            idx_q         <= 3'd5;
            run_q         <= 1'b0;
            frame_q       <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            sh_seg_lsd_q  <= 4'd0;
            sh_seg_msd_q  <= 3'd0;
            sh_min_lsd_q  <= 4'd0;
            sh_min_msd_q  <= 3'd0;
            sh_hora_lsd_q <= 4'd0;
            sh_hora_msd_q <= 3'd0;
        end else begin
            ps_q          <= ps_d;
            idx_q         <= idx_d;
            run_q         <= run_d;
            frame_q       <= frame_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            sh_seg_lsd_q  <= sh_seg_lsd_d;
            sh_seg_msd_q  <= sh_seg_msd_d;
            sh_min_lsd_q  <= sh_min_lsd_d;
            sh_min_msd_q  <= sh_min_msd_d;
            sh_hora_lsd_q <= sh_hora_lsd_d;
            sh_hora_msd_q <= sh_hora_msd_d;
        end
    end

    assign disp_seg   = seg_q;
    assign disp_an    = an_q;
    assign disp_frame = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan (SCAN_DIV=4, BLANK_CYC=1, active-low pins).
// Stimulus pushes the expected {segments, anodes} for each scan slot.
// The monitor pops one entry each time an anode turns on.
module tb_disp_scan;

    logic       disp_clock = 1'b0;
    logic       reset;
    logic [3:0] seg_lsd, min_lsd, hora_lsd;
    logic [2:0] seg_msd, min_msd, hora_msd;
    logic [6:0] disp_seg;
    logic [5:0] disp_an;
    logic       disp_frame;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;
    logic [12:0] exp_q[$];
    logic [5:0]  prev_an;
    logic        prev_frame;
    logic [6:0]  cur_seg;

    disp_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
        .disp_clock(disp_clock), .reset(reset),
        .seg_lsd(seg_lsd), .seg_msd(seg_msd),
        .min_lsd(min_lsd), .min_msd(min_msd),
        .hora_lsd(hora_lsd), .hora_msd(hora_msd),
        .disp_seg(disp_seg), .disp_an(disp_an), .disp_frame(disp_frame)
    );

    always #5 disp_clock = ~disp_clock;

    // Edges since reset release (cyc == k just after edge k)
    always @(posedge disp_clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_edge(input int k);
        while (cyc < k) begin
            @(posedge disp_clock);
            #1;
        end
    endtask

    task automatic set_time(input logic [2:0] hm, input logic [3:0] hl, input logic [2:0] mm,
                            input logic [3:0] ml, input logic [2:0] sm, input logic [3:0] sl);
        hora_msd = hm; hora_lsd = hl; min_msd = mm; min_lsd = ml; seg_msd = sm; seg_lsd = sl;
    endtask

    task automatic push_slot(input logic [6:0] pat, input int idx);
        logic [5:0] one;
        one = 6'b000001 << idx;
        exp_q.push_back({pat, ~one});
    endtask

    task automatic push_frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                              input logic [6:0] p3, input logic [6:0] p4, input logic [6:0] p5);
        push_slot(p0, 0); push_slot(p1, 1); push_slot(p2, 2);
        push_slot(p3, 3); push_slot(p4, 4); push_slot(p5, 5);
    endtask

    // Monitor: check each slot against the scoreboard and check that segments hold within the slot
    always @(negedge disp_clock) begin
        if (disp_an !== 6'h3F && prev_an === 6'h3F) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL slot_unexpected: got seg %h an %h, expected no slot", disp_seg, disp_an);
            end else begin
                chk("slot_seg", {25'd0, disp_seg}, {25'd0, exp_q[0][12:6]});
                chk("slot_an", {26'd0, disp_an}, {26'd0, exp_q[0][5:0]});
                void'(exp_q.pop_front());
            end
            if (disp_an === 6'h3E) chk("frame_before_slot0", {31'd0, prev_frame}, 32'd1);
            cur_seg <= disp_seg;
        end else if (disp_an !== 6'h3F) begin
            chk("seg_hold", {25'd0, disp_seg}, {25'd0, cur_seg});
        end
        prev_an    <= disp_an;
        prev_frame <= disp_frame;
    end

    initial begin
        // Reset, inputs 12:34:56, held for two frames
        reset = 1'b0;
        set_time(3'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6);
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        repeat (2) @(negedge disp_clock);
        chk("rst_seg", {25'd0, disp_seg}, 32'h7F);
        chk("rst_an", {26'd0, disp_an}, 32'h3F);
        chk("rst_frame", {31'd0, disp_frame}, 32'd0);
        @(posedge disp_clock);
        #1 reset = 1'b1;

        wait_edge(3);
        @(negedge disp_clock);
        chk("pre_tick_frame", {31'd0, disp_frame}, 32'd0);
        chk("pre_tick_an", {26'd0, disp_an}, 32'h3F);
        chk("pre_tick_seg", {25'd0, disp_seg}, 32'h7F);
        wait_edge(4);
        @(negedge disp_clock);
        chk("first_frame", {31'd0, disp_frame}, 32'd1);
        chk("first_blank_an", {26'd0, disp_an}, 32'h3F);
        wait_edge(5);
        @(negedge disp_clock);
        chk("frame_one_cycle", {31'd0, disp_frame}, 32'd0);
        chk("slot0_an", {26'd0, disp_an}, 32'h3E);

        // Tearing: change to 23:59:59 during slot 2 of frame 1
        wait_edge(37);
        set_time(3'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9);
        push_frame(7'h10, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24);

        // Invalid digits: min_msd=6, hora_lsd=A
        wait_edge(53);
        set_time(3'd2, 4'hA, 3'd6, 4'd9, 3'd5, 4'd9);
        push_frame(7'h10, 7'h12, 7'h10, 7'h3F, 7'h3F, 7'h24);

        // Hours 07: leading-zero handling
        wait_edge(77);
        set_time(3'd0, 4'd7, 3'd0, 4'd0, 3'd0, 4'd0);
`ifdef DISP_ZERO_BLANK_EN
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h7F);
`else
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h40);
`endif

        // 19:28:37 for frame 5, which is cut by reset during slot 3
        wait_edge(101);
        set_time(3'd1, 4'd9, 3'd2, 4'd8, 3'd3, 4'd7);
        push_slot(7'h78, 0); push_slot(7'h30, 1); push_slot(7'h00, 2); push_slot(7'h24, 3);

        wait_edge(138);
        chk("pre_reset_slot3_an", {26'd0, disp_an}, 32'h37);
        reset = 1'b0;
        #1;
        chk("async_rst_seg", {25'd0, disp_seg}, 32'h7F);
        chk("async_rst_an", {26'd0, disp_an}, 32'h3F);
        chk("async_rst_frame", {31'd0, disp_frame}, 32'd0);
        set_time(3'd2, 4'd0, 3'd1, 4'd5, 3'd4, 4'd8);
        push_frame(7'h00, 7'h19, 7'h12, 7'h79, 7'h40, 7'h24);
        repeat (3) @(posedge disp_clock);
        #1 reset = 1'b1;

        wait_edge(3);
        @(negedge disp_clock);
        chk("restart_pre_frame", {31'd0, disp_frame}, 32'd0);
        chk("restart_pre_an", {26'd0, disp_an}, 32'h3F);
        wait_edge(4);
        @(negedge disp_clock);
        chk("restart_frame", {31'd0, disp_frame}, 32'd1);
        chk("restart_seg", {25'd0, disp_seg}, 32'h00);

        wait_edge(27);
        @(negedge disp_clock);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
